// File: rtl/if_stage_if.sv
// Fetch-stage bus: hazard/redirect controls in, ROM port, IF/ID contents out.
// master = whoever drives controls and ROM data; slave = the fetch stage.
interface if_stage_if;
  logic        stall;
  logic        flush;
  logic        irq;
  logic        exc;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        jr;
  logic [31:0] jr_target;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        irq_ack;
  logic [31:0] epc;

  modport master (
    output stall, flush, irq, exc, br_taken, br_target, jump, jump_target,
           jr, jr_target, rom_data,
    input  rom_addr, if_pc, if_pc_plus4, if_instr, if_valid, irq_ack, epc
  );

  modport slave (
    input  stall, flush, irq, exc, br_taken, br_target, jump, jump_target,
           jr, jr_target, rom_data,
    output rom_addr, if_pc, if_pc_plus4, if_instr, if_valid, irq_ack, epc
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch: PC register, next-PC arbitration, IF/ID pipeline register.
// PC[31] is the kernel-mode bit; sequential fetch and branch/jump never alter it,
// only jr, exceptions, interrupts and reset may.
module if_stage #(
  parameter logic [31:0] RESET_VEC = 32'h8000_0000,
  parameter logic [31:0] IRQ_VEC   = 32'h8000_0004,
  parameter logic [31:0] EXC_VEC   = 32'h8000_0008
) (
  input logic       clk,
  input logic       reset,
  if_stage_if.slave bus
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;

  localparam logic [31:0] MODE_MSK = 32'h8000_0000;

  logic [31:0] pc;
  logic [31:0] seq_pc;
  logic [31:0] next_pc;
  logic        redirect;
  logic        irq_take;
  logic        bubble;
  logic        irq_ack_q;
  logic [31:0] epc_q;
  ifid_t       ifid;

  // Carry out of bit 30 is dropped so the mode bit survives a 31-bit wrap.
  assign seq_pc   = {pc[31], pc[30:0] + 31'd4};
  assign redirect = bus.jr | bus.br_taken | bus.jump;
  // Interrupts only in user mode, and only when nothing else claims the PC.
  assign irq_take = bus.irq & ~pc[31] & ~bus.exc & ~redirect & ~bus.stall;
  assign bubble   = bus.flush | bus.exc | irq_take | redirect;

  // Next-PC arbitration, highest priority first; redirects override stall.
  always_comb begin
    next_pc = seq_pc;
    if (bus.exc)           next_pc = EXC_VEC;
    else if (irq_take)     next_pc = IRQ_VEC;
    else if (bus.jr)       next_pc = bus.jr_target;
    else if (bus.br_taken) next_pc = (bus.br_target & ~MODE_MSK) | (pc & MODE_MSK);
    else if (bus.jump)     next_pc = (bus.jump_target & ~MODE_MSK) | (pc & MODE_MSK);
    else if (bus.stall)    next_pc = pc;
  end

  // PC register with interrupt acknowledge pulse and return-address capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_VEC;
      irq_ack_q <= 1'b0;
      epc_q     <= '0;
    end else begin
      pc        <= next_pc;
      irq_ack_q <= irq_take;
      if (irq_take) epc_q <= pc;
    end
  end

  // IF/ID register: a bubble keeps the old PC fields and only kills the word.
  always_ff @(posedge clk) begin
    if (reset) begin
      ifid <= '0;
    end else if (bubble) begin
      ifid.instr <= '0;
      ifid.valid <= 1'b0;
    end else if (!bus.stall) begin
      ifid.pc       <= pc;
      ifid.pc_plus4 <= seq_pc;
      ifid.instr    <= bus.rom_data;
      ifid.valid    <= 1'b1;
    end
  end

  assign bus.rom_addr    = pc;
  assign bus.if_pc       = ifid.pc;
  assign bus.if_pc_plus4 = ifid.pc_plus4;
  assign bus.if_instr    = ifid.instr;
  assign bus.if_valid    = ifid.valid;
  assign bus.irq_ack     = irq_ack_q;
  assign bus.epc         = epc_q;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage of the MIPS core. It owns the PC register, drives the combinational instruction ROM address, and captures the fetched word into the IF/ID pipeline register. It arbitrates the next PC between reset, exception, interrupt, branch, jump, jr and sequential fetch. PC[31] is the kernel-mode bit.

Parameters:
RESET_VEC  32'h8000_0000  PC loaded on reset
IRQ_VEC    32'h8000_0004  interrupt entry
EXC_VEC    32'h8000_0008  illegal-op/exception entry

Ports:
clk          in   1   clock; all state updates on rising edge
reset        in   1   synchronous, active-high
stall        in   1   hazard unit: hold PC and IF/ID
flush        in   1   load bubble into IF/ID
irq          in   1   level interrupt request from timer
exc          in   1   exception request from decode, 1-cycle pulse
br_taken     in   1   branch resolved taken
br_target    in   32  branch target
jump         in   1   j/jal in decode
jump_target  in   32  {pc_plus4[31:28], imm26, 2'b00}
jr           in   1   jr/jalr in decode
jr_target    in   32  register value
rom_addr     out  32  = PC, combinational
rom_data     in   32  instruction word from ROM
if_pc        out  32  PC of instruction held in IF/ID
if_pc_plus4  out  32  if_pc + 4, bit31 preserved
if_instr     out  32  instruction held in IF/ID
if_valid     out  1   IF/ID holds a real instruction
irq_ack      out  1   1-cycle pulse when interrupt is taken
epc          out  32  return address latched on interrupt

Behaviour:
- Reset (synchronous): PC=RESET_VEC; if_pc=0, if_pc_plus4=0, if_instr=0, if_valid=0, irq_ack=0, epc=0. Reset mid-operation discards all pending state.
- rom_addr=PC. ROM is combinational, so instruction latency is one cycle: the word fetched at PC appears on if_instr after the next edge.
- Sequential PC = {PC[31], PC[30:0]+4}. Bit31 never changes by carry; 31-bit wrap stays in mode.
- Next-PC priority, highest first:
  - exc: PC=EXC_VEC; IF/ID bubble; ignores stall.
  - irq taken: PC=IRQ_VEC; IF/ID bubble; epc=PC; irq_ack=1 for one cycle.
  - jr: PC=jr_target; all 32 bits, so jr may clear bit31 to return from the kernel.
  - br_taken: PC=br_target with bit31 forced to PC[31].
  - jump: PC=jump_target with bit31 forced to PC[31].
  - stall: PC holds.
  - otherwise: sequential.
- Redirects (jr, br_taken, jump) apply even when stall=1. The fetched word is discarded: IF/ID is loaded with a bubble.
- Interrupt is taken only when all hold: irq=1, PC[31]=0, exc=0, no redirect, stall=0. Otherwise it is deferred; irq is level, so it is retried the next cycle. Interrupts are never taken in kernel mode.
- IF/ID update priority:
  - reset.
  - flush | exc | irq taken | redirect: bubble (if_instr=0, if_valid=0, if_pc and if_pc_plus4 unchanged).
  - stall: hold.
  - otherwise: load if_instr=rom_data, if_pc=PC, if_pc_plus4=seq PC, if_valid=1.
- Flush with stall: the bubble wins.
- epc changes only when an interrupt is taken.
- No branch delay slot.

Test Plan:
- Reset, then release with ROM kernel image → rom_addr=0x8000_0000; next cycle if_pc=0x8000_0000, if_instr=0x08000003, if_valid=1; following cycle rom_addr=0x8000_0004.
- Jump from 0x8000_0000 with jump_target=0x0000_000C → PC=0x8000_000C (bit31 kept); IF/ID bubble for one cycle; then if_instr=0x00000820.
- jr_target=0x0040_0000 from kernel → PC=0x0040_0000, bit31 cleared; next if_instr=0x0000e820; PC advances to 0x0040_0004.
- irq=1 while PC=0x0040_0010 in user mode, no stall → irq_ack pulse, epc=0x0040_0010, PC=0x8000_0004, if_valid=0. irq held in kernel mode → no second ack.
- stall=1 for 3 cycles at PC=0x0040_0008 → rom_addr, if_pc and if_instr frozen. stall=1 with br_taken=1, br_target=0x0040_0030 → PC=0x0040_0030, if_valid=0.
- Simultaneous exc, irq and jump → PC=0x8000_0008, no irq_ack, epc unchanged. Reset asserted in the same cycle → PC=0x8000_0000, all outputs zero.
